// File: rtl/multi_cycle_adder_pkg.sv
// Shared types and defaults for the digit-serial adder.
package multi_cycle_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIGIT = 2;

endpackage

// File: rtl/multi_cycle_adder_digit_adder.sv
// Combinational DIGIT-bit ripple adder, one slice of the serial sum.
module digit_adder #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             cm
);

    logic [DIGIT:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign co = c[DIGIT];
    assign cm = c[DIGIT-1];

endmodule

// File: rtl/multi_cycle_adder.sv
// Digit-serial add/subtract: one DIGIT-bit slice per RUN cycle, LSB first.
module multi_cycle_adder
    import multi_cycle_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = $clog2(STEPS + 1);

    if (WIDTH < 2 || WIDTH > 64 || DIGIT < 1 || DIGIT > WIDTH
        || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("multi_cycle_adder: illegal WIDTH/DIGIT combination");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] nxt;
    logic             carry;
    logic [DIGIT-1:0] s;
    logic             co;
    logic             cm;
    int unsigned      off;
    logic             last;

    assign off  = int'(cnt) * DIGIT;
    assign last = (cnt == CW'(STEPS - 1));

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x  (opa[off +: DIGIT]),
        .y  (opb[off +: DIGIT]),
        .ci (carry),
        .s  (s),
        .co (co),
        .cm (cm)
    );

    // Full result with the current slice merged in, used on the last step.
    always_comb begin
        nxt = acc;
        nxt[off +: DIGIT] = s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                        acc   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    carry             <= co;
                    acc[off +: DIGIT] <= s;
                    cnt               <= cnt + 1'b1;
                    if (last) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum      <= nxt;
                        cout     <= co;
                        overflow <= cm ^ co;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Self-checking bench: vector table, random ops vs. arithmetic model, corner sequences.
module tb_multi_cycle_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sub = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy, done, cout, overflow;
    logic [7:0] sum;

    logic       sw_start = 1'b0;
    logic       b1, d1, c1, o1;
    logic       b4, d4, c4, o4;
    logic       b8, d8, c8, o8;
    logic [7:0] s1, s4, s8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multi_cycle_adder #(.WIDTH(8), .DIGIT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .cin(cin), .busy(busy), .done(done), .sum(sum), .cout(cout),
        .overflow(overflow)
    );

    multi_cycle_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(sw_start), .sub(sub), .a(a), .b(b),
        .cin(cin), .busy(b1), .done(d1), .sum(s1), .cout(c1), .overflow(o1)
    );

    multi_cycle_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .start(sw_start), .sub(sub), .a(a), .b(b),
        .cin(cin), .busy(b4), .done(d4), .sum(s4), .cout(c4), .overflow(o4)
    );

    multi_cycle_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst(rst), .start(sw_start), .sub(sub), .a(a), .b(b),
        .cin(cin), .busy(b8), .done(d8), .sum(s8), .cout(c8), .overflow(o8)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Result from signed/unsigned integer arithmetic: {cout, ovf, sum}.
    function automatic logic [9:0] model(input logic [7:0] x, y,
                                         input logic c, s);
        int r, u;
        logic co, ov;
        if (s) begin
            r  = int'($signed(x)) - int'($signed(y));
            co = (x >= y);
        end else begin
            r  = int'($signed(x)) + int'($signed(y)) + int'(c);
            u  = int'(x) + int'(y) + int'(c);
            co = (u > 255);
        end
        ov = (r < -128) || (r > 127);
        return {co, ov, 8'(r)};
    endfunction

    task automatic op(input logic [7:0] ia, ib, input logic ic, is,
                      input logic [7:0] es, input logic ec, eo,
                      input string nm);
        int n;
        @(negedge clk);
        a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
        @(posedge clk); #1;
        chk({nm, " busy"}, 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
        end
        chk({nm, " latency"}, 64'(n), 64'd4);
        chk({nm, " sum"}, 64'(sum), 64'(es));
        chk({nm, " cout/ovf"}, 64'({cout, overflow}), 64'({ec, eo}));
        @(posedge clk); #1;
        chk({nm, " done pulse"}, 64'({done, busy}), 64'd0);
        chk({nm, " hold"}, 64'(sum), 64'(es));
    endtask

    initial begin
        logic [9:0] m;
        logic [7:0] ra, rb;
        logic       rc, rs;
        int n1, n4, n8;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};

        #2;
        chk("reset outputs", 64'({busy, done, sum, cout, overflow}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
               vecs[i].sum, vecs[i].cout, vecs[i].ovf, $sformatf("vec%0d", i));

        for (int i = 0; i < 25; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            m  = model(ra, rb, rc, rs);
            op(ra, rb, rc, rs, m[7:0], m[9], m[8], $sformatf("rand%0d", i));
        end

        // start held through RUN, then back-to-back from DONE
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("held start busy e%0d", i), 64'({busy, done}), 64'd2);
        end
        @(negedge clk);
        a = 8'h10; b = 8'h20; sub = 1'b1;
        @(posedge clk); #1;
        chk("b2b first done", 64'({done, busy}), 64'd2);
        chk("b2b first sum", 64'({sum, cout, overflow}), 64'({8'h96, 2'b01}));
        @(posedge clk); #1;
        chk("b2b restart", 64'({done, busy}), 64'd1);
        @(negedge clk);
        start = 1'b0; a = 8'hFF; b = 8'hFF; sub = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("b2b sum holds in run", 64'(sum), 64'h96);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("b2b second done", 64'(done), 64'd1);
        chk("b2b second sum", 64'({sum, cout, overflow}), 64'({8'hF0, 2'b00}));

        // reset in the middle of RUN
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async reset", 64'({busy, done, sum, cout, overflow}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        n1 = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) n1++;
        end
        chk("no done after abort", 64'(n1), 64'd0);
        op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "after reset");

        // DIGIT sweep on the same add case
        @(negedge clk);
        a = 8'h5A; b = 8'h3C; cin = 1'b0; sub = 1'b0; sw_start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        sw_start = 1'b0; a = 8'h00; b = 8'h00;
        n1 = 0; n4 = 0; n8 = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (d1 && n1 == 0) n1 = i;
            if (d4 && n4 == 0) n4 = i;
            if (d8 && n8 == 0) n8 = i;
        end
        chk("sweep d1 latency", 64'(n1), 64'd8);
        chk("sweep d4 latency", 64'(n4), 64'd2);
        chk("sweep d8 latency", 64'(n8), 64'd1);
        chk("sweep d1 sum", 64'({s1, c1, o1}), 64'({8'h96, 2'b01}));
        chk("sweep d4 sum", 64'({s4, c4, o4}), 64'({8'h96, 2'b01}));
        chk("sweep d8 sum", 64'({s8, c8, o8}), 64'({8'h96, 2'b01}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
